// File: rtl/parity_pkg.sv
// Shared constants for the parity generator/checker.
package parity_pkg;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int unsigned ERR_CNT_W = 16;
  typedef logic [ERR_CNT_W-1:0] err_cnt_t;
  localparam err_cnt_t ERR_CNT_MAX = '1;

endpackage

// File: rtl/parity_xor_tree.sv
// Balanced combinational XOR reduction of a WIDTH-bit word to one even-parity bit.
module parity_xor_tree #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  localparam int unsigned Levels = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int unsigned Leaves = 1 << Levels;

  // Level 0 holds the zero-padded leaves; each further level halves the node count.
  for (genvar l = 0; l <= Levels; l++) begin : g_lvl
    logic [(Leaves >> l)-1:0] node;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < Leaves; i++) begin : g_in
        if (i < WIDTH) begin : g_data
          assign node[i] = data_i[i];
        end else begin : g_pad
          assign node[i] = 1'b0;
        end
      end
    end else begin : g_red
      for (genvar i = 0; i < (Leaves >> l); i++) begin : g_x
        assign node[i] = g_lvl[l-1].node[2*i] ^ g_lvl[l-1].node[2*i+1];
      end
    end
  end

  assign parity_o = g_lvl[Levels].node[0];

endmodule

// File: rtl/parity_gen.sv
// Registered parity generator/checker with one-cycle latency.
// Define PARITY_ERR_CNT_EN to add the saturating err_cnt mismatch counter.
module parity_gen
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  input  logic             odd_sel,
  input  logic             parity_in,
  output logic             parity_comb,
  output logic             parity_out,
  output logic             out_valid,
  output logic             mismatch
`ifdef PARITY_ERR_CNT_EN
  ,
  output err_cnt_t         err_cnt
`endif
);

  logic even_par;
  logic parity_d, parity_q;
  logic mismatch_d, mismatch_q;
  logic valid_q;

  parity_xor_tree #(
    .WIDTH(WIDTH)
  ) u_xor_tree (
    .data_i  (data_in),
    .parity_o(even_par)
  );

  always_comb begin
    parity_d   = even_par ^ (odd_sel == PARITY_ODD);
    mismatch_d = (parity_in != parity_d);
  end

  // Data-path registers only load on in_valid, so idle-cycle data never reaches them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q   <= 1'b0;
      mismatch_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        parity_q   <= parity_d;
        mismatch_q <= mismatch_d;
      end
    end
  end

  assign parity_comb = even_par;
  assign parity_out  = parity_q;
  assign out_valid   = valid_q;
  assign mismatch    = mismatch_q;

`ifdef PARITY_ERR_CNT_EN
  err_cnt_t err_cnt_d, err_cnt_q;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_valid && mismatch_d && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_gen.sv
// Bench for parity_gen: directed literal cases plus randomized traffic against a popcount model.
module tb_parity_gen;
  localparam int W = 8;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic [W-1:0] data_in   = '0;
  logic         in_valid  = 1'b0;
  logic         odd_sel   = 1'b0;
  logic         parity_in = 1'b0;

  logic pc8, po8, ov8, mm8;
  logic pc1, po1, ov1, mm1;
`ifdef PARITY_ERR_CNT_EN
  logic [15:0] cnt8, cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parity_gen #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .odd_sel    (odd_sel),
    .parity_in  (parity_in),
    .parity_comb(pc8),
    .parity_out (po8),
    .out_valid  (ov8),
    .mismatch   (mm8)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt    (cnt8)
`endif
  );

  parity_gen #(.WIDTH(1)) dut_w1 (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in[0]),
    .in_valid   (in_valid),
    .odd_sel    (odd_sel),
    .parity_in  (parity_in),
    .parity_comb(pc1),
    .parity_out (po1),
    .out_valid  (ov1),
    .mismatch   (mm1)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt    (cnt1)
`endif
  );

  // Parity from a plain count of set bits.
  function automatic logic ref_par(input logic [63:0] d, input int w, input logic odd);
    int ones = 0;
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    return ((ones % 2) == 1) ^ odd;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model
  logic m_par8 = 1'b0, m_mm8 = 1'b0, m_par1 = 1'b0, m_mm1 = 1'b0, m_valid = 1'b0;
  int   m_cnt8 = 0, m_cnt1 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_par8 <= 1'b0; m_mm8 <= 1'b0; m_par1 <= 1'b0; m_mm1 <= 1'b0;
      m_valid <= 1'b0; m_cnt8 <= 0; m_cnt1 <= 0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_par8 <= ref_par(64'(data_in), W, odd_sel);
        m_mm8  <= (parity_in != ref_par(64'(data_in), W, odd_sel));
        m_par1 <= ref_par(64'(data_in), 1, odd_sel);
        m_mm1  <= (parity_in != ref_par(64'(data_in), 1, odd_sel));
        if ((parity_in != ref_par(64'(data_in), W, odd_sel)) && m_cnt8 < 65535) m_cnt8 <= m_cnt8 + 1;
        if ((parity_in != ref_par(64'(data_in), 1, odd_sel)) && m_cnt1 < 65535) m_cnt1 <= m_cnt1 + 1;
      end
    end
  end

  // Inputs change at negedge+1, so the negedge sees settled outputs.
  always @(negedge clk) begin
    check("parity_out", po8, m_par8);
    check("out_valid", ov8, m_valid);
    check("mismatch", mm8, m_mm8);
    check("w1_parity_out", po1, m_par1);
    check("w1_out_valid", ov1, m_valid);
    check("w1_mismatch", mm1, m_mm1);
    if (!$isunknown(data_in)) begin
      check("parity_comb", pc8, ref_par(64'(data_in), W, 1'b0));
      check("w1_parity_comb", pc1, ref_par(64'(data_in), 1, 1'b0));
    end
`ifdef PARITY_ERR_CNT_EN
    check("err_cnt", cnt8, 16'(m_cnt8));
    check("w1_err_cnt", cnt1, 16'(m_cnt1));
`endif
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic odd, input logic pin);
    @(negedge clk);
    #1;
    in_valid = v; data_in = d; odd_sel = odd; parity_in = pin;
  endtask

  task automatic expect_out(input string name, input logic par, input logic val, input logic mm);
    @(posedge clk);
    #1;
    check({name, "_par"}, po8, par);
    check({name, "_vld"}, ov8, val);
    check({name, "_mm"}, mm8, mm);
  endtask

  logic [W-1:0] even_in  [5] = '{8'h00, 8'h03, 8'h10, 8'hFF, 8'h7F};
  logic         even_exp [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    // Reset held with a valid all-ones word present
    in_valid = 1'b1; data_in = 8'hFF;
    repeat (2) @(negedge clk);
    #1;
    check("rst_par", po8, 1'b0);
    check("rst_vld", ov8, 1'b0);
    check("rst_mm", mm8, 1'b0);
`ifdef PARITY_ERR_CNT_EN
    check("rst_cnt", cnt8, 16'd0);
`endif
    rst = 1'b0; in_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, even_in[i], 1'b0, even_exp[i]);
      #1;
      check("even_comb", pc8, even_exp[i]);
      expect_out("even", even_exp[i], 1'b1, 1'b0);
    end

    drive(1'b1, 8'h10, 1'b1, 1'b0);
    expect_out("odd10", 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h03, 1'b1, 1'b1);
    expect_out("odd03", 1'b1, 1'b1, 1'b0);
    check("w1_odd03", po1, 1'b0);

    drive(1'b1, 8'h03, 1'b0, 1'b1);
    expect_out("chk_bad", 1'b0, 1'b1, 1'b1);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    expect_out("chk_good", 1'b0, 1'b1, 1'b0);

    drive(1'b1, 8'h10, 1'b0, 1'b1);
    expect_out("gap_pre", 1'b1, 1'b1, 1'b0);
    drive(1'b0, 'x, 1'b1, 1'b0);
    expect_out("gap_x", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, W'($urandom), 1'($urandom), 1'($urandom));
      #1;
      check("gap_comb", pc8, ref_par(64'(data_in), W, 1'b0));
      expect_out("gap", 1'b1, 1'b0, 1'b0);
    end

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset mid-stream, then recovery
    drive(1'b1, 8'h10, 1'b0, 1'b1);
    expect_out("pre_rst", 1'b1, 1'b1, 1'b0);
    #1;
    rst = 1'b1; in_valid = 1'b1; data_in = 8'hFF;
    #1;
    check("mid_rst_par", po8, 1'b0);
    check("mid_rst_vld", ov8, 1'b0);
    check("mid_rst_mm", mm8, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b1; data_in = 8'h03; odd_sel = 1'b1; parity_in = 1'b1;
    #1;
    check("post_rst_idle", ov8, 1'b0);
    expect_out("post_rst", 1'b1, 1'b1, 1'b0);

`ifdef PARITY_ERR_CNT_EN
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      drive(1'b1, d, 1'b0, ~ref_par(64'(d), W, 1'b0));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("cnt_three", cnt8, 16'd3);
    for (int i = 0; i < 65532; i++) drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("cnt_full", cnt8, 16'hFFFF);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("cnt_sat", cnt8, 16'hFFFF);
`endif

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_gen.md
Name: parity_gen

Overview:
- Registered parity generator/checker for a parameterizable data word. Default 8 bits.
- Computes the XOR reduction of the input word, with optional odd-parity inversion, one cycle after a valid input.
- Also compares the computed parity against a supplied parity bit and flags mismatches.
- Sits on datapath interfaces (bus/link protection); purely computational, no backpressure.

Parameters:
- WIDTH, 8, data word width in bits; legal range 1..64.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- data_in  in  WIDTH  word to protect
- in_valid  in  1  data_in (and parity_in) is sampled this cycle
- odd_sel  in  1  0 = even parity, 1 = odd parity; sampled with in_valid
- parity_in  in  1  received parity bit for checking; sampled with in_valid
- parity_comb  out  1  combinational XOR reduction of data_in (even sense, not gated by in_valid)
- parity_out  out  1  registered parity bit
- out_valid  out  1  parity_out/mismatch valid this cycle
- mismatch  out  1  registered; 1 when parity_in differs from the computed parity
- err_cnt  out  16  mismatch counter; present only with PARITY_ERR_CNT_EN

Behaviour:
- Even parity: p = XOR of all bits of data_in. Examples: 8'h00 -> 0, 8'h03 -> 0, 8'h10 -> 1.
- Odd parity: p = ~(XOR of all bits of data_in).
- parity_comb = XOR of all bits of data_in. It is always even sense and has zero latency.
- Reset (async assert, synchronous deassert externally): parity_out = 0, out_valid = 0, mismatch = 0, err_cnt = 0.
- Latency is 1 cycle. On a clk edge with in_valid = 1:
  - parity_out <= p
  - mismatch <= (parity_in != p)
  - out_valid <= 1
- On a clk edge with in_valid = 0:
  - out_valid <= 0
  - parity_out and mismatch hold their previous values.
- Back-to-back valid inputs are accepted every cycle. There is no stall or handshake.
- odd_sel affects only the sample in which it is captured. Changing it between samples is legal.
- Reset asserted mid-stream clears all outputs immediately. The first valid after release produces out_valid on the following edge.
- WIDTH = 1: p = data_in[0] (or its inverse when odd_sel = 1).
- No X propagation from data_in when in_valid = 0 affects the registered outputs.

Optional Feature:
- Macro PARITY_ERR_CNT_EN.
- When defined:
  - err_cnt port exists.
  - Increments by 1 on each clk edge where in_valid = 1 and a mismatch is computed.
  - Saturates at 16'hFFFF.
  - Reset to 0.
- When undefined: err_cnt port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package parity_pkg holds:
  - PARITY_EVEN = 1'b0 and PARITY_ODD = 1'b1 constants for odd_sel encoding
  - ERR_CNT_W = 16 and ERR_CNT_MAX constants
- One sub-module, parity_xor_tree:
  - Parameter WIDTH.
  - Purely combinational, balanced XOR reduction tree of data_in to a 1-bit even parity.
  - Instantiated once; its output drives parity_comb and feeds the registered stage.

Test Plan:
- Reset: assert rst with in_valid = 1 and data_in = 8'hFF -> parity_out = 0, out_valid = 0, mismatch = 0 immediately; err_cnt = 0.
- Even sequence, odd_sel = 0, one sample per cycle:
  - inputs 8'h00, 8'h03, 8'h10, 8'hFF, 8'h7F
  - parity_out one cycle later = 0, 0, 1, 0, 1
  - out_valid = 1 each cycle
- Odd mode, odd_sel = 1:
  - inputs 8'h10, 8'h03
  - parity_out = 0, 1
- Check path:
  - data_in = 8'h03, parity_in = 1, odd_sel = 0 -> mismatch = 1 next cycle.
  - parity_in = 0 -> mismatch = 0.
- Valid gap: in_valid low for 3 cycles after 8'h10 -> out_valid = 0 and parity_out holds 1. parity_comb tracks data_in changes combinationally throughout.
- With PARITY_ERR_CNT_EN:
  - 3 mismatching samples -> err_cnt = 3.
  - Preload by 65535 mismatches, then one more -> err_cnt stays 16'hFFFF.
